// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory between
// instruction fetch (IF) and the data stage (DM). One access in flight at a
// time; arbitration only while idle; DM preferred unless IF has been starved.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | no access in flight; arbitrate between IF and DM
// ST_BUSY_IF  | fetch issued; lat_cnt counts down to the ready cycle
// ST_BUSY_DM  | data access issued; lat_cnt counts down to the ready cycle
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_sel_q, mem_sel_d;
  logic              mem_en_q, mem_en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dm_wins;
  logic              done;

  // Arbitration, grant latching and latency countdown.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_sel_d    = mem_sel_q;
    mem_en_d     = 1'b0;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    // DM is the older instruction, so it wins ties until IF has waited long enough.
    dm_wins = dm_req & (~if_req | (starve_cnt_q < STV_W'(STARVE_MAX)));
    case (state_q)
      ST_IDLE: begin
        if (!if_req) starve_cnt_d = '0;
        if (dm_wins) begin
          state_d     = ST_BUSY_DM;
          lat_cnt_d   = LAT_W'(MEM_LAT);
          mem_en_d    = 1'b1;
          mem_sel_d   = 1'b1;
          we_d        = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req && (starve_cnt_q != STV_W'(STARVE_MAX)))
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (if_req) begin
          state_d      = ST_BUSY_IF;
          lat_cnt_d    = LAT_W'(MEM_LAT);
          mem_en_d     = 1'b1;
          mem_sel_d    = 1'b0;
          we_d         = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (lat_cnt_q == '0) state_d = ST_IDLE;
        else                 lat_cnt_d = lat_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mem_sel_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_sel_q    <= mem_sel_d;
      mem_en_q     <= mem_en_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Ready pulses decode from registered state; read data passes straight through.
  always_comb begin
    done      = (state_q != ST_IDLE) && (lat_cnt_q == '0);
    if_ready  = done && (state_q == ST_BUSY_IF);
    dm_ready  = done && (state_q == ST_BUSY_DM);
    if_rdata  = if_ready ? mem_rdata : '0;
    dm_rdata  = (dm_ready && !we_q) ? mem_rdata : '0;
    mem_sel   = mem_sel_q;
    mem_en    = mem_en_q;
    mem_we    = mem_en_q & we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1/STARVE_MAX=2 instance driven by
// requester tasks with scoreboard queues, plus a MEM_LAT=3 instance for the
// long-latency and reset-abort cases.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  logic clk = 1'b0;
  logic rst_n, rst_n3;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic en_prev = 1'b0;

  // MEM_LAT=1 instance signals
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_sel, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  // MEM_LAT=3 instance signals
  logic        if_req3, dm_req3, dm_we3;
  logic [31:0] if_addr3, dm_addr3, dm_wdata3, mem_rdata3;
  logic        if_ready3, dm_ready3, mem_sel3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  grant_t      grant_q[$];

  int          c1 = 0, c3 = 0;
  logic [31:0] a1, a3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n3),
    .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_ready(dm_ready3), .dm_rdata(dm_rdata3),
    .mem_sel(mem_sel3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {if_ready, dm_ready, mem_sel, mem_en, mem_we}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
  endtask

  task automatic push_grant(input logic sel, input logic [31:0] addr,
                            input logic we, input logic [31:0] wdata);
    grant_t g;
    g.sel = sel; g.addr = addr; g.we = we; g.wdata = wdata;
    grant_q.push_back(g);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Fetch requester: holds req until the ready pulse, returns the ready cycle.
  task automatic do_if(input logic [31:0] addr, output int rdy);
    bit seen;
    if_req = 1'b1; if_addr = addr;
    if_q.push_back(memval(addr));
    rdy = -1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_ready) begin rdy = cyc; seen = 1'b1; break; end
    end
    if_req = 1'b0;
    chk("if_ready_seen", seen, 1);
  endtask

  // Data requester: holds req/we/addr/wdata until the ready pulse.
  task automatic do_dm(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int rdy);
    bit seen;
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    dm_q.push_back(we ? 32'h0 : memval(addr));
    rdy = -1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dm_ready) begin rdy = cyc; seen = 1'b1; break; end
    end
    dm_req = 1'b0;
    chk("dm_ready_seen", seen, 1);
  endtask

  // Memory models: data valid MEM_LAT cycles after mem_en, garbage otherwise.
  always @(posedge clk) begin
    #1;
    mem_rdata = 32'h0BAD_0BAD;
    if (c1 != 0) begin
      c1--;
      if (c1 == 0) mem_rdata = memval(a1);
    end
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      a1 = mem_addr; c1 = 1;
    end
    mem_rdata3 = 32'h0BAD_0BAD;
    if (c3 != 0) begin
      c3--;
      if (c3 == 0) mem_rdata3 = memval(a3);
    end
    if (mem_en3) begin a3 = mem_addr3; c3 = 3; end
  end

  // Scoreboard monitor for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    grant_t g;
    if (mon_en) begin
      chk("ready_excl", if_ready & dm_ready, 0);
      chk("en_consec", mem_en & en_prev, 0);
      en_prev = mem_en;
      if (if_ready) begin
        if (if_q.size() == 0) chk("if_unexpected", if_ready, 0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end else chk("if_rdata_idle", if_rdata, 0);
      if (dm_ready) begin
        if (dm_q.size() == 0) chk("dm_unexpected", dm_ready, 0);
        else chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end else chk("dm_rdata_idle", dm_rdata, 0);
      if (mem_en) begin
        if (grant_q.size() == 0) chk("grant_unexpected", mem_en, 0);
        else begin
          g = grant_q.pop_front();
          chk("mem_sel", mem_sel, g.sel);
          chk("mem_addr", mem_addr, g.addr);
          chk("mem_we", mem_we, g.we);
          chk("mem_wdata", mem_wdata, g.wdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, r1, r2, r, n_en;
    bit seen;
    logic [31:0] exp3;

    rst_n = 1'b0; rst_n3 = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h0;
    if_req3 = 1'b0; if_addr3 = 32'h0; dm_req3 = 1'b0; dm_we3 = 1'b0;
    dm_addr3 = 32'h0; dm_wdata3 = 32'h0;
    mem_rdata = 32'h0BAD_0BAD; mem_rdata3 = 32'h0BAD_0BAD;
    mem_model[32'h10] = 32'h00A0_0093;

    // Reset held 3 cycles with both requests high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mon_en = 1'b1;
      chk_zero("rst");
    end
    rst_n = 1'b1; t0 = cyc;
    push_grant(1'b1, 32'h100, 1'b0, 32'h0);
    push_grant(1'b0, 32'h0, 1'b0, 32'h0);
    fork
      do_dm(1'b0, 32'h100, 32'h0, r1);
      do_if(32'h0, r2);
    join
    chk("rst_first_dm_lat", r1 - t0, 2);
    chk("rst_then_if_lat", r2 - t0, 5);

    // Lone fetch.
    idle(1); t0 = cyc;
    push_grant(1'b0, 32'h10, 1'b0, 32'h0);
    do_if(32'h10, r);
    chk("fetch_lat", r - t0, 2);

    // Contention: DM load wins, IF follows.
    idle(1); t0 = cyc;
    push_grant(1'b1, 32'h200, 1'b0, 32'h0);
    push_grant(1'b0, 32'h40, 1'b0, 32'h0);
    fork
      do_dm(1'b0, 32'h200, 32'h0, r1);
      do_if(32'h40, r2);
    join
    chk("cont_dm_lat", r1 - t0, 2);
    chk("cont_if_lat", r2 - t0, 5);

    // Store, then load the same word back.
    idle(1); t0 = cyc;
    push_grant(1'b1, 32'h204, 1'b1, 32'hDEAD_BEEF);
    do_dm(1'b1, 32'h204, 32'hDEAD_BEEF, r);
    chk("store_lat", r - t0, 2);
    idle(1);
    push_grant(1'b1, 32'h204, 1'b0, 32'h0);
    do_dm(1'b0, 32'h204, 32'h0, r);
    chk("store_readback_model", memval(32'h204), 32'hDEAD_BEEF);

    // Starvation with STARVE_MAX=2: DM,DM,IF,DM,DM,IF.
    idle(1);
    push_grant(1'b1, 32'h300, 1'b0, 32'h0);
    push_grant(1'b1, 32'h304, 1'b0, 32'h0);
    push_grant(1'b0, 32'h80, 1'b0, 32'h0);
    push_grant(1'b1, 32'h308, 1'b0, 32'h0);
    push_grant(1'b1, 32'h30C, 1'b0, 32'h0);
    push_grant(1'b0, 32'h84, 1'b0, 32'h0);
    fork
      begin
        for (int i = 0; i < 4; i++) do_dm(1'b0, 32'h300 + 32'(4 * i), 32'h0, r1);
      end
      begin
        do_if(32'h80, r2);
        do_if(32'h84, r2);
      end
    join
    chk("starve_grants_left", grant_q.size(), 0);

    // Reset mid-transaction: DM granted, reset before completion.
    idle(1);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_wdata = 32'h0;
    push_grant(1'b1, 32'h400, 1'b0, 32'h0);
    @(negedge clk);
    chk("rstmid_en", mem_en, 1);
    rst_n = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    chk_zero("rstmid");
    rst_n = 1'b1;
    idle(4);
    t0 = cyc;
    push_grant(1'b0, 32'h44, 1'b0, 32'h0);
    do_if(32'h44, r);
    chk("post_rst_fetch_lat", r - t0, 2);

    // MEM_LAT=3 instance: normal load latency.
    @(negedge clk); rst_n3 = 1'b1;
    idle(1);
    t0 = cyc; dm_req3 = 1'b1; dm_addr3 = 32'h500; exp3 = memval(32'h500);
    seen = 1'b0; r = -1; n_en = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n_en += int'(mem_en3);
      if (dm_ready3) begin
        seen = 1'b1; r = cyc;
        chk("l3_rdata", dm_rdata3, exp3);
      end
    end
    dm_req3 = 1'b0;
    chk("l3_seen", seen, 1);
    chk("l3_lat", r - t0, 4);
    chk("l3_en_count", n_en, 1);

    // MEM_LAT=3 instance: reset one cycle after grant aborts the access.
    idle(1);
    dm_req3 = 1'b1; dm_addr3 = 32'h504;
    @(negedge clk);
    chk("l3_rstmid_en", mem_en3, 1);
    chk("l3_rstmid_sel", mem_sel3, 1);
    rst_n3 = 1'b0; dm_req3 = 1'b0;
    @(negedge clk);
    chk("l3_rst_outs", {mem_en3, mem_sel3, mem_we3, dm_ready3, if_ready3}, 0);
    chk("l3_rst_addr", mem_addr3, 0);
    chk("l3_rst_rdata", {dm_rdata3, if_rdata3}, 0);
    rst_n3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("l3_abort_en", mem_en3, 0);
      chk("l3_abort_ready", dm_ready3, 0);
    end

    idle(2);
    chk("if_q_left", if_q.size(), 0);
    chk("dm_q_left", dm_q.size(), 0);
    chk("grant_q_left", grant_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
